// File: rtl/rename_free_list_if.sv
// Rename-stage <-> free-list port bundle: allocation request/grant lanes,
// commit-time release lanes and status outputs.
interface rename_free_list_if #(
    parameter int PRF_WIDTH  = 6,
    parameter int DECODE_NUM = 4
);
    logic [DECODE_NUM-1:0] alloc_req;
    logic                  alloc_ready;
    logic [PRF_WIDTH-1:0]  alloc_prd0;
    logic [PRF_WIDTH-1:0]  alloc_prd1;
    logic [PRF_WIDTH-1:0]  alloc_prd2;
    logic [PRF_WIDTH-1:0]  alloc_prd3;
    logic [DECODE_NUM-1:0] release_v;
    logic [PRF_WIDTH-1:0]  release_prd0;
    logic [PRF_WIDTH-1:0]  release_prd1;
    logic [PRF_WIDTH-1:0]  release_prd2;
    logic [PRF_WIDTH-1:0]  release_prd3;
    logic [PRF_WIDTH-1:0]  free_count;
    logic                  overflow_err;

    modport master (
        output alloc_req, release_v,
        output release_prd0, release_prd1, release_prd2, release_prd3,
        input  alloc_ready, alloc_prd0, alloc_prd1, alloc_prd2, alloc_prd3,
        input  free_count, overflow_err
    );

    modport slave (
        input  alloc_req, release_v,
        input  release_prd0, release_prd1, release_prd2, release_prd3,
        output alloc_ready, alloc_prd0, alloc_prd1, alloc_prd2, alloc_prd3,
        output free_count, overflow_err
    );
endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical register tags: up to four in-order grants
// per cycle (all-or-nothing) and up to four commit-time reclaims per cycle.
module rename_free_list #(
    parameter int PRF_WIDTH  = 6,
    parameter int DECODE_NUM = 4,
    parameter int PRF_NUM    = 64,
    parameter int ARF_NUM    = 32,
    parameter int FL_DEPTH   = PRF_NUM - ARF_NUM
) (
    input  logic               clk,
    input  logic               rst,
    rename_free_list_if.slave  fl
);
    localparam int PTR_W = $clog2(FL_DEPTH);
    // Two extra bits: count can transiently reach FL_DEPTH + DECODE_NUM.
    localparam int CNT_W = PTR_W + 2;

    logic [PRF_WIDTH-1:0] fl_mem [FL_DEPTH];
    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 overflow_reg;

    logic [PRF_WIDTH-1:0] rel_prd   [DECODE_NUM];
    logic [PRF_WIDTH-1:0] alloc_prd [DECODE_NUM];
    logic [CNT_W-1:0]     req_ofs   [DECODE_NUM];
    logic [CNT_W-1:0]     rel_ofs   [DECODE_NUM];
    logic [DECODE_NUM-1:0] rel_valid;
    logic [CNT_W-1:0]     n_req;
    logic [CNT_W-1:0]     n_rel;
    logic [CNT_W-1:0]     n_alloc;
    logic [CNT_W-1:0]     count_next;
    logic                 alloc_ok;
    logic                 overflow_now;

    assign rel_prd[0] = fl.release_prd0;
    assign rel_prd[1] = fl.release_prd1;
    assign rel_prd[2] = fl.release_prd2;
    assign rel_prd[3] = fl.release_prd3;

    // Prefix counts give each lane its compacted slot offset from head/tail.
    always_comb begin
        n_req     = '0;
        n_rel     = '0;
        rel_valid = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            req_ofs[i]   = n_req;
            rel_ofs[i]   = n_rel;
            rel_valid[i] = fl.release_v[i] && (rel_prd[i] != '0);
            if (fl.alloc_req[i]) n_req = n_req + 1'b1;
            if (rel_valid[i])    n_rel = n_rel + 1'b1;
        end
    end

    // Grant decision sees only registered count, never same-cycle releases.
    assign alloc_ok     = (count_reg >= n_req);
    assign n_alloc      = alloc_ok ? n_req : '0;
    assign count_next   = count_reg - n_alloc + n_rel;
    assign overflow_now = (count_next > CNT_W'(FL_DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < DECODE_NUM; gi++) begin : gen_alloc_lane
            assign alloc_prd[gi] = (alloc_ok && fl.alloc_req[gi])
                                 ? fl_mem[head_reg + PTR_W'(req_ofs[gi])]
                                 : '0;
        end

        for (gi = 0; gi < FL_DEPTH; gi++) begin : gen_entry
            logic [PRF_WIDTH-1:0] entry_reg;
            logic                 wr_hit;
            logic [PRF_WIDTH-1:0] wr_data;

            always_comb begin
                wr_hit  = 1'b0;
                wr_data = '0;
                for (int i = 0; i < DECODE_NUM; i++) begin
                    if (!overflow_now && rel_valid[i] &&
                        ((tail_reg + PTR_W'(rel_ofs[i])) == PTR_W'(gi))) begin
                        wr_hit  = 1'b1;
                        wr_data = rel_prd[i];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= PRF_WIDTH'(ARF_NUM + gi);
                end else if (wr_hit) begin
                    entry_reg <= wr_data;
                end
            end

            assign fl_mem[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= CNT_W'(FL_DEPTH);
            overflow_reg <= 1'b0;
        end else begin
            head_reg <= head_reg + PTR_W'(n_alloc);
            if (overflow_now) begin
                count_reg    <= count_reg - n_alloc;
                overflow_reg <= 1'b1;
            end else begin
                tail_reg  <= tail_reg + PTR_W'(n_rel);
                count_reg <= count_next;
            end
        end
    end

    assign fl.alloc_ready  = alloc_ok;
    assign fl.alloc_prd0   = alloc_prd[0];
    assign fl.alloc_prd1   = alloc_prd[1];
    assign fl.alloc_prd2   = alloc_prd[2];
    assign fl.alloc_prd3   = alloc_prd[3];
    assign fl.free_count   = PRF_WIDTH'(count_reg);
    assign fl.overflow_err = overflow_reg;
endmodule

// File: tb/tb_rename_free_list.sv
// Scoreboarded random + directed bench for rename_free_list; the reference
// model is a plain queue of free tags.
module tb_rename_free_list;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rename_free_list_if #(.PRF_WIDTH(6), .DECODE_NUM(4)) fl();

    rename_free_list #(
        .PRF_WIDTH(6), .DECODE_NUM(4), .PRF_NUM(64), .ARF_NUM(32), .FL_DEPTH(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    typedef struct packed {
        logic            ready;
        logic [3:0][5:0] prd;
        logic [5:0]      fc;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    int   m_free[$];
    bit   m_ovf;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    task automatic model_reset();
        m_free.delete();
        for (int k = 0; k < 32; k++) m_free.push_back(32 + k);
        m_ovf = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the expected response, advance model.
    task automatic step(input bit r, input logic [3:0] req, input logic [3:0] rv,
                        input logic [5:0] t0, input logic [5:0] t1,
                        input logic [5:0] t2, input logic [5:0] t3);
        exp_t       e;
        int         nreq;
        int         k;
        logic [5:0] tags [4];
        int         rel_list[$];
        @(posedge clk);
        #1;
        rst             = r;
        fl.alloc_req    = req;
        fl.release_v    = rv;
        fl.release_prd0 = t0;
        fl.release_prd1 = t1;
        fl.release_prd2 = t2;
        fl.release_prd3 = t3;
        tags = '{t0, t1, t2, t3};
        nreq = $countones(req);
        e.ready = (m_free.size() >= nreq);
        e.fc    = 6'(m_free.size());
        e.ovf   = m_ovf;
        e.prd   = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && e.ready) begin
                e.prd[i] = 6'(m_free[k]);
                k++;
            end
        end
        sb.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (e.ready) repeat (nreq) void'(m_free.pop_front());
            for (int i = 0; i < 4; i++)
                if (rv[i] && tags[i] != 6'd0) rel_list.push_back(int'(tags[i]));
            if (m_free.size() + rel_list.size() > 32) m_ovf = 1'b1;
            else foreach (rel_list[j]) m_free.push_back(rel_list[j]);
        end
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t            e;
        logic [3:0][5:0] got_prd;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got_prd = {fl.alloc_prd3, fl.alloc_prd2, fl.alloc_prd1, fl.alloc_prd0};
                $display("txn %0d req=%b rel_v=%b ready=%0b prd=%0d,%0d,%0d,%0d free=%0d ovf=%0b",
                         txn, fl.alloc_req, fl.release_v, fl.alloc_ready,
                         fl.alloc_prd0, fl.alloc_prd1, fl.alloc_prd2, fl.alloc_prd3,
                         fl.free_count, fl.overflow_err);
                total++;
                if (fl.alloc_ready !== e.ready) begin
                    bad++;
                    $display("FAIL txn%0d alloc_ready got %b want %b", txn, fl.alloc_ready, e.ready);
                end
                total++;
                if (got_prd !== e.prd) begin
                    bad++;
                    $display("FAIL txn%0d alloc_prd got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", txn,
                             got_prd[0], got_prd[1], got_prd[2], got_prd[3],
                             e.prd[0], e.prd[1], e.prd[2], e.prd[3]);
                end
                total++;
                if (fl.free_count !== e.fc) begin
                    bad++;
                    $display("FAIL txn%0d free_count got %0d want %0d", txn, fl.free_count, e.fc);
                end
                total++;
                if (fl.overflow_err !== e.ovf) begin
                    bad++;
                    $display("FAIL txn%0d overflow_err got %b want %b", txn, fl.overflow_err, e.ovf);
                end
                txn++;
            end
        end
    end

    initial begin
        rst             = 1'b1;
        fl.alloc_req    = '0;
        fl.release_v    = '0;
        fl.release_prd0 = '0;
        fl.release_prd1 = '0;
        fl.release_prd2 = '0;
        fl.release_prd3 = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Sparse request straight out of reset.
        step(1'b0, 4'b1010, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        step(1'b0, 4'b0001, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

        // Full drain in groups of four, then a stalled ninth request.
        step(1'b1, 4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        repeat (9) step(1'b0, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        idle();

        // Release into an empty list and reuse across the wrap point.
        step(1'b0, 4'b0000, 4'b1011, 6'd7, 6'd5, 6'd0, 6'd9);
        step(1'b0, 4'b1110, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        idle();

        // Stall with count=2 while four tags are released in the same cycle.
        step(1'b0, 4'b0000, 4'b0011, 6'd20, 6'd21, 6'd0, 6'd0);
        step(1'b0, 4'b1111, 4'b1111, 6'd10, 6'd11, 6'd12, 6'd13);
        idle();

        // P0 release is dropped.
        step(1'b0, 4'b0000, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0);
        idle();

        // Overflow from a full list is sticky and leaves count at 32.
        step(1'b1, 4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        step(1'b0, 4'b0000, 4'b0001, 6'd40, 6'd0, 6'd0, 6'd0);
        idle();
        step(1'b0, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        idle();

        // Random mixed traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0), 4'($urandom), 4'($urandom),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        // Reset mid-operation with pending traffic, then a fresh full grant.
        step(1'b1, 4'b1111, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4);
        step(1'b0, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        idle();

        @(posedge clk);
        #1;
        fl.alloc_req = '0;
        fl.release_v = '0;
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
